// File: rtl/tl_video_bus_arbiter.sv
// tl_video_bus_arbiter: 2:1 TileLink-UL arbiter sharing one memory A/D port.
// Master 0 (video scan-out) has fixed priority, bounded by a starvation limit
// that guarantees master 1 service. Multi-beat Puts lock the grant, and D beats
// are routed back by the MSB of the slave-side source ID.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   FREE  | owner chosen combinationally each cycle
//   HOLD  | request stalled by the slave; owner frozen until it is accepted
//   BURST | multi-beat Put in flight; owner locked until the last beat
module tl_video_bus_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int SOURCE_WIDTH  = 2,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     m0_a_valid,
  output logic                     m0_a_ready,
  input  logic [2:0]               m0_a_opcode,
  input  logic [2:0]               m0_a_param,
  input  logic [2:0]               m0_a_size,
  input  logic [SOURCE_WIDTH-1:0]  m0_a_source,
  input  logic [ADDRESS_WIDTH-1:0] m0_a_address,
  input  logic [7:0]               m0_a_mask,
  input  logic [63:0]              m0_a_data,
  output logic                     m0_d_valid,
  input  logic                     m0_d_ready,
  output logic [2:0]               m0_d_opcode,
  output logic [2:0]               m0_d_param,
  output logic [2:0]               m0_d_size,
  output logic [SOURCE_WIDTH-1:0]  m0_d_source,
  output logic                     m0_d_denied,
  output logic [63:0]              m0_d_data,
  output logic                     m0_d_corrupt,

  input  logic                     m1_a_valid,
  output logic                     m1_a_ready,
  input  logic [2:0]               m1_a_opcode,
  input  logic [2:0]               m1_a_param,
  input  logic [2:0]               m1_a_size,
  input  logic [SOURCE_WIDTH-1:0]  m1_a_source,
  input  logic [ADDRESS_WIDTH-1:0] m1_a_address,
  input  logic [7:0]               m1_a_mask,
  input  logic [63:0]              m1_a_data,
  output logic                     m1_d_valid,
  input  logic                     m1_d_ready,
  output logic [2:0]               m1_d_opcode,
  output logic [2:0]               m1_d_param,
  output logic [2:0]               m1_d_size,
  output logic [SOURCE_WIDTH-1:0]  m1_d_source,
  output logic                     m1_d_denied,
  output logic [63:0]              m1_d_data,
  output logic                     m1_d_corrupt,

  output logic                     s_a_valid,
  input  logic                     s_a_ready,
  output logic [2:0]               s_a_opcode,
  output logic [2:0]               s_a_param,
  output logic [2:0]               s_a_size,
  output logic [SOURCE_WIDTH:0]    s_a_source,
  output logic [ADDRESS_WIDTH-1:0] s_a_address,
  output logic [7:0]               s_a_mask,
  output logic [63:0]              s_a_data,
  input  logic                     s_d_valid,
  output logic                     s_d_ready,
  input  logic [2:0]               s_d_opcode,
  input  logic [2:0]               s_d_param,
  input  logic [2:0]               s_d_size,
  input  logic [SOURCE_WIDTH:0]    s_d_source,
  input  logic                     s_d_denied,
  input  logic [63:0]              s_d_data,
  input  logic                     s_d_corrupt
);

  typedef enum logic [1:0] {FREE = 2'd0, HOLD = 2'd1, BURST = 2'd2} state_t;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic       owner_q, owner;
  logic [2:0] beats_q, beats_d;
  logic [7:0] starve_q, starve_d;

  logic       a_fire;
  logic       first_fire;
  logic       a_multi;
  logic [2:0] size_eff;
  logic [3:0] span;
  logic [2:0] first_beats;

  // State register: owner, lock/hold state, remaining beats and starvation count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FREE;
      owner_q  <= 1'b0;
      beats_q  <= 3'd0;
      starve_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner;
      beats_q  <= beats_d;
      starve_q <= starve_d;
    end
  end

  // Grant select: free arbitration only in FREE, otherwise the owner is frozen
  always_comb begin
    owner = owner_q;
    if (state_q == FREE) begin
      if (m0_a_valid && !m1_a_valid)      owner = 1'b0;
      else if (!m0_a_valid && m1_a_valid) owner = 1'b1;
      else if (m0_a_valid && m1_a_valid)  owner = (starve_q == STARVE_MAX);
    end
  end

  // Burst decode on the presented beat; sizes above 64 bytes clamp to 8 beats
  always_comb begin
    a_fire      = s_a_valid && s_a_ready;
    first_fire  = a_fire && (state_q != BURST);
    a_multi     = ((s_a_opcode == 3'd0) || (s_a_opcode == 3'd1)) && (s_a_size > 3'd3);
    size_eff    = (s_a_size > 3'd6) ? 3'd6 : s_a_size;
    span        = 4'd1 << (size_eff - 3'd3);
    first_beats = 3'(span - 4'd1);
  end

  // Next-state: stall hold, burst lock/countdown and starvation bookkeeping
  always_comb begin
    state_d  = state_q;
    beats_d  = beats_q;
    starve_d = starve_q;
    case (state_q)
      FREE, HOLD: begin
        if (a_fire) begin
          if (a_multi) begin
            state_d = BURST;
            beats_d = first_beats;
          end else begin
            state_d = FREE;
          end
        end else if (s_a_valid) begin
          state_d = HOLD;
        end
      end
      BURST: begin
        if (a_fire) begin
          beats_d = beats_q - 3'd1;
          if (beats_q == 3'd1) state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase

    if (!m1_a_valid)                                    starve_d = 8'd0;
    else if (first_fire && owner)                       starve_d = 8'd0;
    else if (first_fire && !owner && starve_q != STARVE_MAX) starve_d = starve_q + 8'd1;
  end

  // Outputs: zero-latency A mux to the owner, D demux by source MSB
  always_comb begin
    s_a_valid   = owner ? m1_a_valid   : m0_a_valid;
    s_a_opcode  = owner ? m1_a_opcode  : m0_a_opcode;
    s_a_param   = owner ? m1_a_param   : m0_a_param;
    s_a_size    = owner ? m1_a_size    : m0_a_size;
    s_a_source  = {owner, owner ? m1_a_source : m0_a_source};
    s_a_address = owner ? m1_a_address : m0_a_address;
    s_a_mask    = owner ? m1_a_mask    : m0_a_mask;
    s_a_data    = owner ? m1_a_data    : m0_a_data;
    m0_a_ready  = s_a_ready && !owner;
    m1_a_ready  = s_a_ready &&  owner;

    m0_d_valid  = s_d_valid && !s_d_source[SOURCE_WIDTH];
    m1_d_valid  = s_d_valid &&  s_d_source[SOURCE_WIDTH];
    s_d_ready   = s_d_source[SOURCE_WIDTH] ? m1_d_ready : m0_d_ready;

    m0_d_opcode  = s_d_opcode;
    m0_d_param   = s_d_param;
    m0_d_size    = s_d_size;
    m0_d_source  = s_d_source[SOURCE_WIDTH-1:0];
    m0_d_denied  = s_d_denied;
    m0_d_data    = s_d_data;
    m0_d_corrupt = s_d_corrupt;
    m1_d_opcode  = s_d_opcode;
    m1_d_param   = s_d_param;
    m1_d_size    = s_d_size;
    m1_d_source  = s_d_source[SOURCE_WIDTH-1:0];
    m1_d_denied  = s_d_denied;
    m1_d_data    = s_d_data;
    m1_d_corrupt = s_d_corrupt;
  end

endmodule
